// File: rtl/xalu_seq.sv
// xalu_seq: nibble-serial word sequencer driving one 4-bit xalu slice; optional self-check built when XALU_SEQ_SELFCHECK_EN is defined
module xalu_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4*NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         zero,
  output logic         eq,
  output logic         err,
  output logic [3:0]   sl_a,
  output logic [3:0]   sl_b,
  output logic [3:0]   sl_f,
  output logic         sl_ci_right,
  output logic         sl_ci_left,
  input  logic [3:0]   sl_d,
  input  logic         sl_co_left,
  input  logic         sl_co_right,
  input  logic         sl_equ
);
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES-1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, sel;
  logic [W-1:0] opa_r, opb_r, wres, merged;
  logic [3:0] op_r;
  logic carry, eqr, shr, run, last, nxt_c, keep_c, go;
  assign run = state == RUN;
  assign go = state == IDLE && start;
  assign shr = op_r == 4'd6;
  assign sel = shr ? LAST - idx : idx;
  assign last = idx == LAST;
  assign nxt_c = shr ? sl_co_right : sl_co_left;
  assign keep_c = op_r == 4'd0 || op_r == 4'd6 || op_r == 4'd7;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign sl_a = run ? opa_r[4*sel +: 4] : 4'h0;
  assign sl_b = run ? opb_r[4*sel +: 4] : 4'h0;
  assign sl_f = op_r;
  assign sl_ci_right = run & ~shr & carry;
  assign sl_ci_left = run & shr & carry;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: one pass per nibble, then a single done cycle
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  // working word with the current slice nibble dropped into place
  always_comb begin
    merged = wres;
    merged[4*sel +: 4] = sl_d;
  end
  // operand latch, nibble walk and result publication on the final pass
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      opa_r <= '0;
      opb_r <= '0;
      op_r <= '0;
      carry <= 1'b0;
      eqr <= 1'b0;
      wres <= '0;
      result <= '0;
      cout <= 1'b0;
      zero <= 1'b0;
      eq <= 1'b0;
    end else if (go) begin
      idx <= '0;
      opa_r <= opa;
      opb_r <= opb;
      op_r <= op;
      carry <= cin;
      eqr <= 1'b1;
      wres <= '0;
    end else if (run) begin
      idx <= idx + 1'b1;
      wres <= merged;
      carry <= nxt_c;
      eqr <= eqr & sl_equ;
      if (last) begin
        result <= merged;
        cout <= keep_c & nxt_c;
        zero <= merged == '0;
        eq <= eqr & sl_equ;
      end
    end
`ifdef XALU_SEQ_SELFCHECK_EN
  logic [3:0] exp_d;
  logic [4:0] sum;
  logic exp_c, bad;
  assign sum = {1'b0, sl_a} + {1'b0, sl_b} + {4'b0, carry};
  assign bad = run && op_r < 4'd9 && (sl_d != exp_d || nxt_c != exp_c);
  // what a healthy slice must return for the nibble being driven
  always_comb begin
    exp_d = 4'h0;
    exp_c = 1'b0;
    case (op_r)
      4'd0: {exp_c, exp_d} = sum;
      4'd1: exp_d = sl_a & sl_b;
      4'd2: exp_d = sl_a | sl_b;
      4'd3: exp_d = sl_a ^ sl_b;
      4'd4: exp_d = sl_a;
      4'd5: exp_d = sl_b;
      4'd6: {exp_d, exp_c} = {carry, sl_a};
      4'd7: {exp_c, exp_d} = {sl_a, carry};
      4'd8: exp_d = ~sl_a;
      default: ;
    endcase
  end
  // sticky mismatch flag, cleared by the next accepted start
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else if (go) err <= 1'b0;
    else if (bad) err <= 1'b1;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_xalu_seq.sv
// tb_xalu_seq: table, random and corner-sequence checks of xalu_seq against a word-level model
module tb_xalu_seq;
  localparam int N = 4;
  localparam int W = 4*N;
  logic clk = 0, rst = 1, start = 0, cin = 0;
  logic [3:0] op = 0;
  logic [W-1:0] opa = 0, opb = 0;
  logic busy, done, cout, zero, eq, err, sl_ci_right, sl_ci_left, sl_co_left, sl_co_right, sl_equ;
  logic [W-1:0] result;
  logic [3:0] sl_a, sl_b, sl_f, sl_d, m_d;
  logic m_cl, m_cr, corrupt = 0, corrupt_en = 0;
  int n = 0, fails = 0, na = 0;
  logic [3:0] sla [16];
  logic err_exp;

  xalu_seq #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero), .eq(eq), .err(err),
    .sl_a(sl_a), .sl_b(sl_b), .sl_f(sl_f), .sl_ci_right(sl_ci_right), .sl_ci_left(sl_ci_left),
    .sl_d(sl_d), .sl_co_left(sl_co_left), .sl_co_right(sl_co_right), .sl_equ(sl_equ));

  always #5 clk = ~clk;

  // combinational 4-bit slice the sequencer talks to
  always_comb begin
    m_d = 4'h0;
    m_cl = 1'b0;
    m_cr = 1'b0;
    case (sl_f)
      4'd0: {m_cl, m_d} = {1'b0, sl_a} + {1'b0, sl_b} + {4'b0, sl_ci_right};
      4'd1: m_d = sl_a & sl_b;
      4'd2: m_d = sl_a | sl_b;
      4'd3: m_d = sl_a ^ sl_b;
      4'd4: m_d = sl_a;
      4'd5: m_d = sl_b;
      4'd6: begin m_d = {sl_ci_left, sl_a[3:1]}; m_cr = sl_a[0]; end
      4'd7: begin m_d = {sl_a[2:0], sl_ci_right}; m_cl = sl_a[3]; end
      4'd8: m_d = ~sl_a;
      default: ;
    endcase
  end
  assign sl_d = m_d ^ {3'b0, corrupt};
  assign sl_co_left = m_cl;
  assign sl_co_right = m_cr;
  assign sl_equ = sl_a == sl_b;

  typedef struct {
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic c;
    logic [W-1:0] r;
    logic rc, rz, re;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // whole-word behaviour of one operation
  task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output logic [W-1:0] r, output logic rc, output logic rz, output logic re);
    logic [W:0] s;
    r = '0;
    rc = 1'b0;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    case (o)
      4'd0: begin r = s[W-1:0]; rc = s[W]; end
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = a ^ b;
      4'd4: r = a;
      4'd5: r = b;
      4'd6: begin r = {c, a[W-1:1]}; rc = a[0]; end
      4'd7: begin r = {a[W-2:0], c}; rc = a[W-1]; end
      4'd8: r = ~a;
      default: ;
    endcase
    rz = r == '0;
    re = a == b;
  endtask

  task automatic do_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int t;
    @(negedge clk);
    start = 1; op = o; opa = a; opb = b; cin = c;
    @(negedge clk);
    start = 0;
    t = 0;
    na = 0;
    while (!done && t < 20) begin
      if (na < 16) begin sla[na] = sl_a; na++; end
      corrupt = corrupt_en && t == 1;
      @(negedge clk);
      corrupt = 0;
      t++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_word(input string tag, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W-1:0] r;
    logic rc, rz, re;
    model(o, a, b, c, r, rc, rz, re);
    chk({tag, "_result"}, 32'(result), 32'(r));
    chk({tag, "_cout"}, 32'(cout), 32'(rc));
    chk({tag, "_zero"}, 32'(zero), 32'(rz));
    chk({tag, "_eq"}, 32'(eq), 32'(re));
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_passes"}, na, N);
    for (int i = 0; i < N; i++) begin
      int k;
      k = o == 4'd6 ? N-1-i : i;
      chk({tag, "_sl_a_seq"}, 32'(sla[i]), 32'(a[4*k +: 4]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a, b, held;
`ifdef XALU_SEQ_SELFCHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    tbl[0] = '{4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{4'd6, 16'h8001, 16'h0000, 1'b1, 16'hC000, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{4'd7, 16'h8001, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{4'd8, 16'h00F0, 16'h0000, 1'b0, 16'hFF0F, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{4'd3, 16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{4'd0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{4'd1, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{4'd12, 16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{4'd5, 16'h0000, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", {cout, zero, eq, err}, 0);
    chk("rst_slice", {sl_a, sl_b, sl_f, sl_ci_right, sl_ci_left}, 0);
    rst = 0;
    // cycle-exact busy/done window for the first ADD
    @(negedge clk);
    start = 1; op = 0; opa = 16'hFFFF; opb = 16'h0001; cin = 0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 0;
      chk($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= 5));
      chk($sformatf("done_c%0d", c), 32'(done), 32'(c == 5));
    end
    chk("first_add_result", 32'(result), 32'h0000);
    chk("first_add_cout", 32'(cout), 1);
    // vector table
    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c);
      chk($sformatf("tbl%0d_result", i), 32'(result), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_cout", i), 32'(cout), 32'(tbl[i].rc));
      chk($sformatf("tbl%0d_zero", i), 32'(zero), 32'(tbl[i].rz));
      chk($sformatf("tbl%0d_eq", i), 32'(eq), 32'(tbl[i].re));
      chk($sformatf("tbl%0d_err", i), 32'(err), 0);
      chk($sformatf("tbl%0d_idle_slice", i), {sl_a, sl_b, sl_ci_right, sl_ci_left}, 0);
      chk($sformatf("tbl%0d_sl_f", i), 32'(sl_f), 32'(tbl[i].op));
      if (tbl[i].op == 4'd6)
        for (int j = 0; j < N; j++) chk("shr_sl_a_seq", 32'(sla[j]), 32'(tbl[i].a[4*(N-1-j) +: 4]));
    end
    // random operations against the word model
    for (int i = 0; i < 150; i++) begin
      logic [3:0] o;
      logic c;
      o = 4'($urandom_range(0, 15));
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      c = 1'($urandom);
      do_op(o, a, b, c);
      check_word("rand", o, a, b, c);
    end
    // start while busy is ignored
    do_op(4'd5, 16'h0000, 16'h1111, 1'b0);
    @(negedge clk);
    start = 1; op = 4'd4; opa = 16'h5A5A; opb = 16'h0000; cin = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1; op = 4'd5; opb = 16'h7777;
    @(negedge clk);
    start = 0;
    begin
      int t, extra;
      t = 0;
      while (!done && t < 20) begin @(negedge clk); t++; end
      chk("busy_start_done_seen", 32'(done), 1);
      chk("busy_start_result", 32'(result), 32'h5A5A);
      extra = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      chk("busy_start_no_second_op", extra, 0);
      chk("busy_start_result_held", 32'(result), 32'h5A5A);
    end
    // asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1; op = 4'd0; opa = 16'h1234; opb = 16'h0FCD; cin = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_result", 32'(result), 0);
    chk("midrst_slice", {sl_a, sl_b, sl_f, sl_ci_right, sl_ci_left}, 0);
    chk("midrst_flags", {cout, zero, eq, err}, 0);
    @(negedge clk);
    rst = 0;
    do_op(4'd0, 16'h1234, 16'h0FCD, 1'b0);
    chk("postrst_result", 32'(result), 32'h2201);
    chk("postrst_cout", 32'(cout), 0);
    // slice fault on nibble 2 of an ADD
    corrupt_en = 1;
    do_op(4'd0, 16'h1234, 16'h0FCD, 1'b0);
    corrupt_en = 0;
    chk("fault_err", 32'(err), 32'(err_exp));
    @(negedge clk);
    chk("fault_err_sticky", 32'(err), 32'(err_exp));
    do_op(4'd2, 16'h00FF, 16'h0F00, 1'b0);
    chk("fault_err_cleared", 32'(err), 0);
    chk("fault_next_result", 32'(result), 32'h0FFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/xalu_seq.md
Name: xalu_seq

Overview:
Multi-cycle word sequencer that drives one external 4-bit xalu slice to perform W-bit operations, one nibble per cycle. The sequencer presents operand nibbles, the function code and the carry-in to the slice. It collects the result nibbles, carries and flags, and assembles the word result. It sits between the core control logic and a single slice, and acts as the initiator for the slice's combinational responder.

Parameters:
NIBBLES, 4, number of slice passes; word width W = 4*NIBBLES (minimum 2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  4  function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL, 8 COM
opa  input  W  operand A
opb  input  W  operand B
cin  input  1  word carry/shift-in
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
result  output  W  assembled result; held until next start
cout  output  1  word carry/shift-out
zero  output  1  result == 0
eq  output  1  opa == opb
err  output  1  self-check mismatch (see Optional Feature)
sl_a  output  4  slice port A nibble
sl_b  output  4  slice port B nibble
sl_f  output  4  slice function code
sl_ci_right  output  1  slice right carry-in
sl_ci_left  output  1  slice left carry-in
sl_d  input  4  slice result nibble
sl_co_left  input  1  slice left carry-out
sl_co_right  input  1  slice right carry-out
sl_equ  input  1  slice A=B

Behaviour:
- FSM states: IDLE, RUN, DONE. Nibble index counter idx is clog2(NIBBLES) bits wide.
- Reset (async, any state): state IDLE, idx 0, and all outputs 0 (busy, done, result, cout, zero, eq, err, sl_*). sl_f=0.
- IDLE + start: latch opa, opb, op, cin. Go to RUN with idx=0. Carry register = cin. eq register = 1.
- Nibble order:
  - LSB first (idx maps to nibble idx) for every op except SHR.
  - SHR goes MSB first (nibble NIBBLES-1-idx).
- Slice drive in RUN, from registers, stable for the whole cycle:
  - sl_a and sl_b = the selected nibbles; sl_f = latched op.
  - sl_ci_right = carry register for non-SHR ops, else 0.
  - sl_ci_left = carry register for SHR, else 0.
- Each RUN clock edge:
  - Write sl_d into the selected result nibble.
  - eq register &= sl_equ.
  - Carry register <= sl_co_right for SHR, else sl_co_left.
  - idx++.
- Leaving RUN: after the edge where idx == NIBBLES-1, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - cout = final carry register for ADD, SHL and SHR; 0 for all other ops.
  - zero = (result == 0). eq = eq register.
- Latency: start sampled at edge k. RUN occupies cycles k+1..k+NIBBLES. done is high in cycle k+NIBBLES+1. busy is high from cycle k+1 through the done cycle inclusive.
- start while busy: ignored, with no queuing.
- Outside RUN, sl_a, sl_b, sl_ci_right and sl_ci_left are 0. sl_f holds its last value.
- Codes 9-15: sequence normally. The slice returns 0, so result=0, cout=0, zero=1.
- result, cout, zero and eq hold until the next accepted start. They update only at DONE.

Optional Feature:
Macro XALU_SEQ_SELFCHECK_EN.
- Defined: the sequencer computes the expected nibble and carry internally for codes 0-8, using the same rules as the slice. Any RUN-cycle mismatch with sl_d or the chained carry sets err. err is sticky until the next accepted start or reset.
- Undefined: err is tied to 0 and no checking logic is built.

Test Plan:
- ADD opa=0xFFFF, opb=0x0001, cin=0, started at cycle 0 -> result=0x0000, cout=1, zero=1, eq=0; done only in cycle 5; busy high in cycles 1-5.
- SHR opa=0x8001, cin=1 -> result=0xC000, cout=1; sl_a sequence 8,0,0,1.
- SHL opa=0x8001, cin=0 -> result=0x0002, cout=1. COM opa=0x00F0 -> result=0xFF0F, cout=0.
- XOR opa=opb=0xA5A5 -> result=0, zero=1, eq=1. ADD 0x1234+0x0FCD -> 0x2201, cout=0.
- start pulsed in cycle 2 of an operation -> ignored, result unchanged. rst asserted mid-RUN -> next cycle busy=0, result=0, sl_*=0; a fresh start then runs to completion.
- Bench forces sl_d nibble 2 wrong during ADD -> err=1 with XALU_SEQ_SELFCHECK_EN, err=0 without; err clears on the next start.
